// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, result select, register-file write port,
// forwarding info and retire/stall performance counters.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              mem_valid,
    input  logic              mem_wb_en,
    input  logic              mem_r_en,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic [DATA_W-1:0] mem_alu_res,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              WB_EN_ID,
    output logic [REG_W-1:0]  dest_ID,
    output logic [DATA_W-1:0] val_ID,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_dest,
    output logic              err_r15,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_W-1:0] REG_R15 = REG_W'(15);

    logic              v_r;
    logic              wb_r;
    logic              rd_r;
    logic [REG_W-1:0]  dest_r;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] rdata_r;
    logic              done_r;
    logic              err_r15_r;
    logic [CNT_W-1:0]  retired_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              wr_pending_s;
    logic              retire_s;
    logic              wb_en_s;

    // Stage status decode; everything here depends on registered state only.
    always_comb begin
        wr_pending_s = v_r & wb_r & ~done_r;
        retire_s     = v_r & ~done_r;
        if (wr_pending_s && (dest_r != REG_R15)) begin
            wb_en_s = 1'b1;
        end else begin
            wb_en_s = 1'b0;
        end
    end

    // MEM/WB pipeline register; done marks an instruction already written back and retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r     <= 1'b0;
            wb_r    <= 1'b0;
            rd_r    <= 1'b0;
            dest_r  <= {REG_W{1'b0}};
            alu_r   <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
            done_r  <= 1'b0;
        end else if (!freeze) begin
            v_r     <= mem_valid;
            wb_r    <= mem_wb_en;
            rd_r    <= mem_r_en;
            dest_r  <= mem_dest;
            alu_r   <= mem_alu_res;
            rdata_r <= mem_rdata;
            done_r  <= 1'b0;
        end else if (v_r) begin
            done_r  <= 1'b1;
        end else begin
            done_r  <= done_r;
        end
    end

    // Sticky r15 error and free-running wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r15_r     <= 1'b0;
            retired_cnt_r <= {CNT_W{1'b0}};
            stall_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (wr_pending_s && (dest_r == REG_R15)) begin
                err_r15_r <= 1'b1;
            end else begin
                err_r15_r <= err_r15_r;
            end
            if (retire_s) begin
                retired_cnt_r <= retired_cnt_r + CNT_W'(1);
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end
            if (freeze) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign WB_EN_ID    = wb_en_s;
    assign dest_ID     = dest_r;
    assign val_ID      = rd_r ? rdata_r : alu_r;
    assign fwd_en      = wb_en_s;
    assign fwd_dest    = dest_r;
    assign err_r15     = err_r15_r;
    assign retired_cnt = retired_cnt_r;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage that captures MEM-stage results into the MEM/WB pipeline register and selects the load data or the ALU result. It drives the register file write port (WB_EN_ID, dest_ID, val_ID), which the register file samples on negedge clk. A cache-miss freeze can hold the stage; the stage guarantees each instruction writes back and retires exactly once. It also exports forwarding info and retire/stall performance counters.

Parameters:
DATA_W, 32, datapath width
REG_W, 4, register index width
CNT_W, 32, performance counter width

Ports:
clk  in  1  system clock; stage register updates on posedge
rst  in  1  reset: asynchronous, active-high
freeze  in  1  cache-miss stall; hold stage contents
mem_valid  in  1  MEM stage holds a real instruction
mem_wb_en  in  1  instruction writes a register
mem_r_en  in  1  instruction is a load
mem_dest  in  REG_W  destination register
mem_alu_res  in  DATA_W  ALU result or address
mem_rdata  in  DATA_W  data returned by cache/memory
WB_EN_ID  out  1  register file write enable
dest_ID  out  REG_W  register file write index
val_ID  out  DATA_W  register file write data
fwd_en  out  1  forwarding valid for the hazard unit; equals WB_EN_ID
fwd_dest  out  REG_W  forwarding index; equals dest_ID
err_r15  out  1  sticky: write-back to r15 attempted
retired_cnt  out  CNT_W  instructions retired
stall_cnt  out  CNT_W  cycles with freeze=1

Behaviour:
- Reset, asynchronous: all stage registers are cleared. This covers v, wb, rd, dest, alu, rdata and done. err_r15=0, retired_cnt=0, stall_cnt=0.
- Outputs under reset: WB_EN_ID=0, dest_ID=0, val_ID=0.
- Load at posedge clk with freeze=0: the stage registers take the mem_* inputs and done<=0. Latency from MEM inputs to register-file write is 1 posedge, with the write occurring at the following negedge.
- Hold at posedge clk with freeze=1: the stage registers hold their values. If v=1, done<=1.
- Result select, combinational from the stage registers: val_ID = rd ? rdata : alu.
- dest_ID = dest.
- WB_EN_ID = v & wb & ~done & (dest != 15).
- r15 handling: the register file holds r0..r14 only. If v & wb & ~done & dest==15, there is no write and err_r15<=1 at posedge. err_r15 is cleared only by rst.
- Retire: retired_cnt increments at posedge when v & ~done, whether or not the instruction writes a register. Under freeze, a held instruction therefore counts once.
- Stall counter: stall_cnt increments at posedge when freeze=1.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation.
- freeze=1 with v=0: hold the stage; no retire and no write. stall_cnt still increments.
- freeze falling: at the next posedge new data loads and done clears. The instruction held under freeze does not retire again.
- Simultaneous: a posedge that loads a new instruction also retires the old one if it still has done=0.
- Reset asserted mid-freeze: the pending write is dropped and all state clears immediately, without waiting for clk.
- No combinational path from freeze to WB_EN_ID. WB_EN_ID depends on registered state only, so it is stable across the negedge write.

Test Plan:
- Reset release, then mem_valid=1, wb_en=1, r_en=0, dest=3, alu=0x1234 -> after 1 posedge: WB_EN_ID=1, dest_ID=3, val_ID=0x1234. At the next posedge retired_cnt=1.
- Load: r_en=1, alu=0x100, rdata=0xDEADBEEF, dest=7 -> val_ID=0xDEADBEEF, dest_ID=7, WB_EN_ID=1.
- Load an instruction with dest=5 and val=42, then hold freeze=1 for 4 cycles:
  - WB_EN_ID is high only in the first cycle, then 0.
  - retired_cnt goes up by exactly 1.
  - stall_cnt=4.
  - After freeze drops, the next instruction loads normally.
- dest=15, wb_en=1 -> WB_EN_ID stays 0; err_r15=1 and stays 1 across later instructions; retired_cnt still increments.
- mem_valid=0 with freeze=0 and freeze=1 -> WB_EN_ID=0; retired_cnt is unchanged.
- Preload retired_cnt to 0xFFFFFFFF via force, retire one instruction -> retired_cnt=0.
- Assert rst asynchronously mid-freeze -> all outputs are 0 before the next clk edge.
